// File: rtl/ahfp_cordic_arbiter.sv
// Round-robin arbiter sharing one pipelined ahfp_cordic between two requesters.
// A tag shift register matched to the CORDIC latency steers each result back to its issuer.
module ahfp_cordic_arbiter #(
    parameter int unsigned CORDIC_LATENCY  = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic [31:0] req0_theta,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    input  logic [31:0] req1_theta,

    output logic        rsp0_valid,
    output logic [31:0] rsp0_x_cos,
    output logic [31:0] rsp0_y_sin,

    output logic        rsp1_valid,
    output logic [31:0] rsp1_x_cos,
    output logic [31:0] rsp1_y_sin,

    output logic [31:0] cordic_x_start,
    output logic [31:0] cordic_y_start,
    output logic [31:0] cordic_theta,
    input  logic [31:0] cordic_x_cos,
    input  logic [31:0] cordic_y_sin,

    output logic        busy
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_e;

    rr_e        rr, rr_next;
    logic [3:0] outstanding0, outstanding1;
    logic       elig0, elig1;
    logic       grant0, grant1;

    // Stage k holds the tag for the operation issued k+1 cycles ago; the last
    // stage lines up with the CORDIC output for that operation.
    logic [CORDIC_LATENCY:0] tag_valid;
    logic [CORDIC_LATENCY:0] tag_id;
    logic                    exit_valid;
    logic                    exit_id;

    assign exit_valid = tag_valid[CORDIC_LATENCY];
    assign exit_id    = tag_id[CORDIC_LATENCY];

    always_comb begin
        elig0   = req0_valid && (outstanding0 < MAX_CNT);
        elig1   = req1_valid && (outstanding1 < MAX_CNT);
        grant0  = 1'b0;
        grant1  = 1'b0;
        rr_next = rr;
        if (elig0 && (!elig1 || rr == RR_REQ0)) begin
            grant0  = 1'b1;
            rr_next = RR_REQ1;
        end else if (elig1) begin
            grant1  = 1'b1;
            rr_next = RR_REQ0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr <= RR_REQ0;
        end else begin
            rr <= rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cordic_x_start <= '0;
            cordic_y_start <= '0;
            cordic_theta   <= '0;
        end else if (grant0) begin
            cordic_x_start <= req0_x;
            cordic_y_start <= req0_y;
            cordic_theta   <= req0_theta;
        end else if (grant1) begin
            cordic_x_start <= req1_x;
            cordic_y_start <= req1_y;
            cordic_theta   <= req1_theta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid <= {tag_valid[CORDIC_LATENCY-1:0], grant0 | grant1};
            tag_id    <= {tag_id[CORDIC_LATENCY-1:0], grant1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp0_x_cos <= '0;
            rsp0_y_sin <= '0;
            rsp1_valid <= 1'b0;
            rsp1_x_cos <= '0;
            rsp1_y_sin <= '0;
        end else begin
            rsp0_valid <= exit_valid && !exit_id;
            rsp1_valid <= exit_valid && exit_id;
            if (exit_valid && !exit_id) begin
                rsp0_x_cos <= cordic_x_cos;
                rsp0_y_sin <= cordic_y_sin;
            end
            if (exit_valid && exit_id) begin
                rsp1_x_cos <= cordic_x_cos;
                rsp1_y_sin <= cordic_y_sin;
            end
        end
    end

    // Decrement on the response strobe cycle, so a requester at its limit can
    // handshake again only from the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding0 <= '0;
            outstanding1 <= '0;
        end else begin
            case ({grant0, rsp0_valid})
                2'b10:   outstanding0 <= outstanding0 + 4'd1;
                2'b01:   if (outstanding0 != '0) outstanding0 <= outstanding0 - 4'd1;
                default: outstanding0 <= outstanding0;
            endcase
            case ({grant1, rsp1_valid})
                2'b10:   outstanding1 <= outstanding1 + 4'd1;
                2'b01:   if (outstanding1 != '0) outstanding1 <= outstanding1 - 4'd1;
                default: outstanding1 <= outstanding1;
            endcase
        end
    end

    assign busy = (|tag_valid) || (outstanding0 != '0) || (outstanding1 != '0);

endmodule
